// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if: IR/memory handshake in, datapath control strobes out.
// The sequencer uses the master side and the datapath uses the slave side.
interface ctrl_sequencer_if;
    logic [31:0] IR;
    logic        mem_ready;
    logic        PCout, Zlowout, Zhighout, MDRout;
    logic        MARin, Zin, PCin, MDRin, IRin, Yin, LOin, HIin;
    logic        IncPC, Read;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [4:0]  alu_op;
    modport master (
        input  IR, mem_ready,
        output PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op
    );
    modport slave (
        output IR, mem_ready,
        input  PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin,
               LOin, HIin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hard-wired Mini-SRC control unit (fetch/decode/execute strobes).
// Define ILLEGAL_TRAP_EN to add a sticky illegal output and halt on illegal opcodes.
module ctrl_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             Clock,
    input  logic             clear,
    ctrl_sequencer_if.master bus,
    output logic             run,
    output logic             bus_err,
    output logic [CNT_W-1:0] retired
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic             illegal
`endif
);
    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_t;
    localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TO = TW'(MEM_TIMEOUT);
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif
    state_t        state, state_nx;
    logic [TW-1:0] cnt;
    logic [4:0]    op;
    logic          is_alu, is_md, is_nop, is_halt, is_ill, timeout, retire;
    logic          unused_ir;
    assign op        = bus.IR[31:27];
    assign unused_ir = ^bus.IR[26:0];
    assign is_alu    = op inside {5'd3, 5'd4, 5'd5, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
    assign is_md     = op == 5'd15 || op == 5'd16;
    assign is_nop    = op == 5'd26;
    assign is_halt   = op == 5'd27;
    assign is_ill    = !(is_alu || is_md || is_nop || is_halt);
    assign timeout   = MEM_TIMEOUT != 0 && state == T1 && !bus.mem_ready && cnt + TW'(1) == TO;
    assign retire    = (state == T3 && !is_alu && !is_md && !(TRAP && is_ill)) ||
                       (state == T5 && is_alu) || state == T6;
    assign run       = state != HALT;
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) state <= T0;
        else        state <= state_nx;
    end
    // Wait counter saturates so a MEM_TIMEOUT of 0 never re-pulses PCin.
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear) begin
            cnt     <= '0;
            bus_err <= 1'b0;
            retired <= '0;
        end else begin
            cnt <= (state == T1 && !bus.mem_ready) ? (&cnt ? cnt : cnt + TW'(1)) : '0;
            if (timeout) bus_err <= 1'b1;
            if (retire)  retired <= retired + CNT_W'(1);
        end
    end
`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge Clock or negedge clear) begin
        if (!clear)                      illegal <= 1'b0;
        else if (state == T3 && is_ill)  illegal <= 1'b1;
    end
`endif
    always_comb begin
        state_nx = state;
        case (state)
            T0:      state_nx = T1;
            T1:      state_nx = bus.mem_ready ? T2 : timeout ? HALT : T1;
            T2:      state_nx = T3;
            T3:      state_nx = (is_alu || is_md) ? T4 : (is_halt || (TRAP && is_ill)) ? HALT : T0;
            T4:      state_nx = T5;
            T5:      state_nx = is_alu ? T0 : T6;
            T6:      state_nx = T0;
            default: state_nx = HALT;
        endcase
    end
    // Strobes are forced low while clear is held, even though state already reads T0.
    always_comb begin
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.Zin      = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.alu_op   = 5'd0;
        if (clear) begin
            case (state)
                T0: begin
                    bus.PCout = 1'b1;
                    bus.MARin = 1'b1;
                    bus.IncPC = 1'b1;
                    bus.Zin   = 1'b1;
                end
                T1: begin
                    bus.Zlowout = 1'b1;
                    bus.Read    = 1'b1;
                    bus.MDRin   = 1'b1;
                    bus.PCin    = cnt == '0;
                end
                T2: begin
                    bus.MDRout = 1'b1;
                    bus.IRin   = 1'b1;
                end
                T3: begin
                    bus.Grb  = is_alu;
                    bus.Gra  = is_md;
                    bus.Rout = is_alu || is_md;
                    bus.Yin  = is_alu || is_md;
                end
                T4: begin
                    bus.Grc    = is_alu;
                    bus.Grb    = !is_alu;
                    bus.Rout   = 1'b1;
                    bus.Zin    = 1'b1;
                    bus.alu_op = op;
                end
                T5: begin
                    bus.Zlowout = 1'b1;
                    bus.Gra     = is_alu;
                    bus.Rin     = is_alu;
                    bus.LOin    = !is_alu;
                end
                T6: begin
                    bus.Zhighout = 1'b1;
                    bus.HIin     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
